// File: rtl/ln_pipe.sv
// Pipelined fixed-point natural log: y = k*ln2 + ln(1.m), with the mantissa term
// taken from a parameter-generated table and optionally linearly interpolated.
module ln_pipe #(
   parameter int WIDTH    = 16,
   parameter int FRAC     = 10,
   parameter int LUT_BITS = 6,
   parameter int XMIN     = 10,
   parameter int INTERP   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] x_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] ln_out,
   output logic                    clamp_flag,
   output logic                    busy
);

   localparam int STAGES = 4;
   localparam int NT     = 2**LUT_BITS;
   localparam int FW     = WIDTH-1-LUT_BITS;
   localparam int TW     = FRAC+2;
   localparam int PW     = $clog2(WIDTH);
   localparam int KW     = PW+2;
   localparam int SW     = WIDTH+LUT_BITS+2;
   localparam int PRW    = FW+TW;
   localparam int SCL    = 30;

   // ln(1 + i/NT) * 2^FRAC, rounded half-up, via 2*atanh(i/(2*NT+i)) in SCL-bit fixed point.
   function automatic longint ln_fix(input int i);
      longint z, z2, term, acc;
      z    = (longint'(i) <<< SCL) / longint'(2*NT + i);
      z2   = (z * z) >>> SCL;
      term = z;
      acc  = 0;
      for (longint n = 1; n < 64; n += 2) begin
         acc  = acc + term / n;
         term = (term * z2) >>> SCL;
      end
      return ((2 * acc) + (longint'(1) <<< (SCL-FRAC-1))) >>> (SCL-FRAC);
   endfunction

   localparam logic [TW-1:0]        LN2  = TW'(ln_fix(NT));
   localparam logic [PRW-1:0]       HALF = PRW'(2**(FW-1));
   localparam logic signed [SW-1:0] YMAX = SW'(2**(WIDTH-1)-1);
   localparam logic signed [SW-1:0] YMIN = ~YMAX;

   logic [TW-1:0] tab [0:NT];
   for (genvar g = 0; g <= NT; g++) begin : g_tab
      localparam logic [TW-1:0] TV = TW'(ln_fix(g));
      assign tab[g] = TV;
   end

   logic [STAGES:1] vld_q;
   logic            adv;

   assign out_valid = vld_q[STAGES];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign busy      = |vld_q;

   // S1: clamp and leading-one detect
   logic signed [WIDTH-1:0] xc_d;
   logic                    clmp_d;
   logic [PW-1:0]           p_d;
   always_comb begin
      clmp_d = (x_in < XMIN);
      xc_d   = clmp_d ? WIDTH'(XMIN) : x_in;
      p_d    = '0;
      for (int i = 0; i < WIDTH-1; i++)
         if (xc_d[i]) p_d = PW'(i);
   end

   logic [WIDTH-1:0] s1_x_q;
   logic [PW-1:0]    s1_p_q;
   logic             s1_c_q;

   // S2: left-align the bits below the leading one, split into idx/f
   logic [WIDTH-2:0]       norm_d;
   logic [LUT_BITS-1:0]    idx_d;
   logic [FW-1:0]          f_d;
   logic signed [KW-1:0]   k_d;
   always_comb begin
      norm_d = (WIDTH-1)'(s1_x_q << (PW'(WIDTH-1) - s1_p_q));
      idx_d  = norm_d[WIDTH-2 -: LUT_BITS];
      f_d    = norm_d[FW-1:0];
      k_d    = $signed({2'b00, s1_p_q}) - $signed(KW'(FRAC));
   end

   logic [LUT_BITS-1:0]  s2_idx_q;
   logic [FW-1:0]        s2_f_q;
   logic signed [KW-1:0] s2_k_q;
   logic                 s2_c_q;

   // S3: fetch both interval endpoints
   logic [LUT_BITS:0] ia_d, ib_d;
   logic [TW-1:0]     t0_d, t1_d;
   always_comb begin
      ia_d = {1'b0, s2_idx_q};
      ib_d = ia_d + 1'b1;
      t0_d = tab[ia_d];
      t1_d = tab[ib_d];
   end

   logic [TW-1:0]        s3_t0_q, s3_t1_q;
   logic [FW-1:0]        s3_f_q;
   logic signed [KW-1:0] s3_k_q;
   logic                 s3_c_q;

   // S4: interpolate, add k*ln2, saturate
   logic [TW-1:0]           dlt_d, r_d;
   logic [PRW-1:0]          prod_d;
   logic signed [SW-1:0]    ks_d, ln2s_d, t0s_d, rs_d, y_d;
   logic signed [WIDTH-1:0] sat_d;
   always_comb begin
      dlt_d  = s3_t1_q - s3_t0_q;
      prod_d = {{TW{1'b0}}, s3_f_q} * {{FW{1'b0}}, dlt_d};
      r_d    = TW'((prod_d + HALF) >> FW);
      ks_d   = {{(SW-KW){s3_k_q[KW-1]}}, s3_k_q};
      ln2s_d = {{(SW-TW){1'b0}}, LN2};
      t0s_d  = {{(SW-TW){1'b0}}, s3_t0_q};
      rs_d   = (INTERP != 0) ? {{(SW-TW){1'b0}}, r_d} : '0;
      y_d    = ks_d * ln2s_d + t0s_d + rs_d;
      if (y_d > YMAX)      sat_d = {1'b0, {(WIDTH-1){1'b1}}};
      else if (y_d < YMIN) sat_d = {1'b1, {(WIDTH-1){1'b0}}};
      else                 sat_d = y_d[WIDTH-1:0];
   end

   // One global enable: every stage moves together or nothing moves.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q      <= '0;
         s1_x_q     <= '0;
         s1_p_q     <= '0;
         s1_c_q     <= 1'b0;
         s2_idx_q   <= '0;
         s2_f_q     <= '0;
         s2_k_q     <= '0;
         s2_c_q     <= 1'b0;
         s3_t0_q    <= '0;
         s3_t1_q    <= '0;
         s3_f_q     <= '0;
         s3_k_q     <= '0;
         s3_c_q     <= 1'b0;
         ln_out     <= '0;
         clamp_flag <= 1'b0;
      end else if (adv) begin
         vld_q      <= {vld_q[STAGES-1:1], in_valid};
         s1_x_q     <= xc_d;
         s1_p_q     <= p_d;
         s1_c_q     <= clmp_d;
         s2_idx_q   <= idx_d;
         s2_f_q     <= f_d;
         s2_k_q     <= k_d;
         s2_c_q     <= s1_c_q;
         s3_t0_q    <= t0_d;
         s3_t1_q    <= t1_d;
         s3_f_q     <= s2_f_q;
         s3_k_q     <= s2_k_q;
         s3_c_q     <= s2_c_q;
         ln_out     <= sat_d;
         clamp_flag <= s3_c_q;
      end
   end

endmodule

// File: tb/tb_ln_pipe.sv
// Directed bench for ln_pipe: reset, latency, clamping, stall/backpressure,
// full-range sweep (interpolated and table-only builds) and mid-flight reset.
module tb_ln_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n, in_valid, out_ready;
   logic signed [15:0] x_in;
   logic               in_ready, out_valid, clamp_flag, busy;
   logic signed [15:0] ln_out;
   logic               in_ready0, out_valid0, clamp_flag0, busy0;
   logic signed [15:0] ln_out0;

   int total = 0;
   int bad   = 0;
   int tab [0:64];

   ln_pipe #(.INTERP(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .out_valid(out_valid), .out_ready(out_ready), .ln_out(ln_out),
      .clamp_flag(clamp_flag), .busy(busy));

   ln_pipe #(.INTERP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .x_in(x_in),
      .out_valid(out_valid0), .out_ready(out_ready), .ln_out(ln_out0),
      .clamp_flag(clamp_flag0), .busy(busy0));

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic int lead(input int x);
      int p = 0;
      for (int i = 0; i < 15; i++) if (x[i]) p = i;
      return p;
   endfunction

   // Single isolated transfer; returns edges-to-out_valid (-1 on timeout) and the result.
   task automatic send_one(input int x, output int lat, output int y, output logic c);
      logic got = 1'b0;
      in_valid = 1'b1;
      x_in     = 16'(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      for (int e = 0; e < 12 && !got; e++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
         else begin @(posedge clk); #1; lat++; end
      end
      if (!got) lat = -1;
      y = int'(ln_out);
      c = clamp_flag;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic seen = 1'b0;
      rst_n = 1'b0; in_valid = 1'b1; x_in = 16'sd2048; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (ln_out !== 16'sd0) begin bad++; $display("FAIL rst_ln_out: got %0d want 0", ln_out); end
      total++; if (clamp_flag !== 1'b0) begin bad++; $display("FAIL rst_clamp: got %b want 0", clamp_flag); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_discard: got out_valid=%b want 0", seen); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int xs[4], ys[4];
      int lat, y;
      logic c;
      xs = '{1024, 2048, 512, 10240};
      ys = '{0, 710, -710, 2358};
      for (int i = 0; i < 4; i++) begin
         send_one(xs[i], lat, y, c);
         total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency x=%0d: got %0d want 4", xs[i], lat); end
         total++; if (y !== ys[i]) begin bad++; $display("FAIL basic_value x=%0d: got %0d want %0d", xs[i], y, ys[i]); end
         total++; if (c !== 1'b0) begin bad++; $display("FAIL basic_clamp x=%0d: got %b want 0", xs[i], c); end
      end
   endtask

   task automatic test_clamp();
      int xs[4];
      logic cs[4];
      int lat, y;
      logic c;
      xs = '{0, -5, 9, 10};
      cs = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         send_one(xs[i], lat, y, c);
         total++; if (y !== -4742) begin bad++; $display("FAIL clamp_value x=%0d: got %0d want -4742", xs[i], y); end
         total++; if (c !== cs[i]) begin bad++; $display("FAIL clamp_flag x=%0d: got %b want %b", xs[i], c, cs[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int xs[8], ys[8];
      logic cs[8];
      int sent = 0, rcv = 0, nstall = 0;
      logic prev_stall = 1'b0;
      logic signed [15:0] prev_y = '0;
      xs = '{1024, 2048, 512, 10240, 4096, 256, 0, 8192};
      ys = '{0, 710, -710, 2358, 1420, -1420, -4742, 2130};
      cs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int cyc = 1; cyc <= 40; cyc++) begin
         in_valid  = (sent < 8);
         x_in      = (sent < 8) ? 16'(xs[sent]) : 16'sd0;
         out_ready = !(cyc >= 5 && cyc <= 7);
         @(negedge clk);
         if (prev_stall) begin
            total++; if (ln_out !== prev_y) begin bad++; $display("FAIL b2b_hold cyc=%0d: got %0d want %0d", cyc, ln_out, prev_y); end
         end
         if (out_valid && !out_ready) begin
            nstall++;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready cyc=%0d: got %b want 0", cyc, in_ready); end
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = ln_out;
         if (out_valid && out_ready) begin
            if (rcv < 8) begin
               total++; if (ln_out !== 16'(ys[rcv])) begin bad++; $display("FAIL b2b_value #%0d: got %0d want %0d", rcv, ln_out, ys[rcv]); end
               total++; if (clamp_flag !== cs[rcv]) begin bad++; $display("FAIL b2b_clamp #%0d: got %b want %b", rcv, clamp_flag, cs[rcv]); end
            end
            rcv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (rcv !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", rcv); end
      total++; if (nstall !== 3) begin bad++; $display("FAIL b2b_stall_cycles: got %0d want 3", nstall); end
   endtask

   task automatic test_sweep();
      localparam int N = 32767 - 10 + 1;
      int sent = 0, r1 = 0, r0 = 0;
      int x, p, want0;
      real ideal, diff;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < N + 30; cyc++) begin
         in_valid = (sent < N);
         x_in     = 16'(10 + sent);
         @(negedge clk);
         if (out_valid) begin
            x = 10 + r1;
            p = lead(x);
            // ln2 is a fixed 710-code constant, so the k term uses it exactly
            ideal = real'((p - 10) * 710) + 1024.0 * $ln(real'(x) / (2.0 ** p));
            diff  = real'(int'(ln_out)) - ideal;
            if (diff < 0.0) diff = -diff;
            total++; if (diff > 2.0) begin bad++; $display("FAIL sweep_interp x=%0d: got %0d want %f +-2", x, ln_out, ideal); end
            r1++;
         end
         if (out_valid0) begin
            x = 10 + r0;
            p = lead(x);
            want0 = (p - 10) * 710 + tab[((x << (15 - p)) & 32'h7fff) >> 9];
            total++; if (int'(ln_out0) !== want0) begin bad++; $display("FAIL sweep_table x=%0d: got %0d want %0d", x, ln_out0, want0); end
            r0++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++; if (r1 !== N) begin bad++; $display("FAIL sweep_count_interp: got %0d want %0d", r1, N); end
      total++; if (r0 !== N) begin bad++; $display("FAIL sweep_count_table: got %0d want %0d", r0, N); end
   endtask

   task automatic test_mid_reset();
      int xs[3];
      int lat, y;
      logic c, seen = 1'b0;
      xs = '{1024, 2048, 512};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; x_in = 16'(xs[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_inflight_busy: got %b want 1", busy); end
      rst_n = 1'b0; in_valid = 1'b1; x_in = 16'sd8192;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      total++; if (ln_out !== 16'sd0) begin bad++; $display("FAIL mid_ln_out: got %0d want 0", ln_out); end
      total++; if (clamp_flag !== 1'b0) begin bad++; $display("FAIL mid_clamp: got %b want 0", clamp_flag); end
      repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_stale: got out_valid=%b want 0", seen); end
      @(posedge clk); #1;
      send_one(4096, lat, y, c);
      total++; if (y !== 1420) begin bad++; $display("FAIL mid_first_result: got %0d want 1420", y); end
      total++; if (lat !== 4) begin bad++; $display("FAIL mid_latency: got %0d want 4", lat); end
   endtask

   initial begin
      for (int i = 0; i <= 64; i++)
         tab[i] = $rtoi($ln(1.0 + real'(i) / 64.0) * 1024.0 + 0.5);
      rst_n = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
      #1;
      test_reset();
      test_basic();
      test_clamp();
      test_back_to_back();
      test_sweep();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
